mandel_pixel_sequencer: RTL and testbench

Frame-level controller for the Mandelbrot accelerator. Walks a raster pointer across the image from top-left to bottom-right and issues one pixel coordinate at a time to the iteration engine over a valid/ready handshake. Waits for the engine's escape count, maps it to a colour and writes that colour to the framebuffer. Sits between the host start/status registers and the iteration engine/framebuffer pair.

---
 rtl/mandel_pkg.sv | 19 +
 rtl/mandel_pixel_sequencer_if.sv | 36 +++
 rtl/mandel_colour_map.sv | 35 +++
 rtl/mandel_pixel_sequencer.sv | 128 ++++++++++++
 tb/tb_mandel_pixel_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot pixel sequencer: FSM state encoding,
// 24-bit RGB colour type and the fixed colour constants.
// Latency: n/a (types only). Backpressure: n/a.
package mandel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COL_BLACK = 24'h000000;
  localparam rgb_t COL_RED   = 24'hFF0000;

endpackage

// File: rtl/mandel_pixel_sequencer_if.sv
// Engine/framebuffer side bundle of the pixel sequencer.
// Latency: n/a (wires only). Backpressure: px_valid/px_ready on the coordinate path.
// master = sequencer: drives px_x/px_y/px_valid and fb_we/fb_addr/fb_data,
//          receives px_ready and the result strobe res_valid/res_escaped/res_iter.
// slave  = engine + framebuffer model: the mirror image.
interface mandel_pixel_sequencer_if #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ITER_W = 8
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = $clog2(IMG_W * IMG_H);

  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic              px_valid;
  logic              px_ready;
  logic              res_valid;
  logic              res_escaped;
  logic [ITER_W-1:0] res_iter;
  logic              fb_we;
  logic [AW-1:0]     fb_addr;
  logic [23:0]       fb_data;

  modport master (
    output px_x, px_y, px_valid, fb_we, fb_addr, fb_data,
    input  px_ready, res_valid, res_escaped, res_iter
  );

  modport slave (
    input  px_x, px_y, px_valid, fb_we, fb_addr, fb_data,
    output px_ready, res_valid, res_escaped, res_iter
  );

endinterface

// File: rtl/mandel_colour_map.sv
// Maps an engine result (escaped flag + iteration count) to an RGB888 colour.
// Latency: combinational. Backpressure: none.
// Ports: escaped, iter in; colour out.
// Macro ITER_COLOUR_EN: escaped pixels get an iteration gradient instead of pure red.
module mandel_colour_map
  import mandel_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              escaped,
  input  logic [ITER_W-1:0] iter,
  output rgb_t              colour
);

`ifdef ITER_COLOUR_EN
  // Top 8 bits of the count drive red up and blue down.
  logic [7:0] lvl;
  assign lvl = iter[ITER_W-1 -: 8];

  always_comb begin
    colour = COL_BLACK;
    if (escaped) colour = {lvl, 8'h00, 8'hFF - lvl};
  end
`else
  // Binary set image: iteration count carries no information here.
  logic unused_iter;
  assign unused_iter = ^iter;

  always_comb begin
    colour = COL_BLACK;
    if (escaped) colour = COL_RED;
  end
`endif

endmodule

// File: rtl/mandel_pixel_sequencer.sv
// Raster-walks the image, issues one coordinate at a time to the iteration engine,
// colours the result and writes it to the framebuffer.
// Latency: 3 cycles per pixel plus engine latency; all outputs registered.
// Backpressure: coordinate held stable while px_valid && !px_ready; one pixel outstanding.
// Ports: clk, rst (sync, active high), start/abort in, busy/done out,
//        bus (master modport): px_*, res_*, fb_* engine and framebuffer signals.
// Macro ITER_COLOUR_EN (in mandel_colour_map) selects gradient colouring.
module mandel_pixel_sequencer
  import mandel_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ITER_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  mandel_pixel_sequencer_if.master bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr;    // tracks y*IMG_W+x by increment, no multiplier
  logic          valid_q;
  logic          we_q;
  rgb_t          data_q;
  rgb_t          colour;

  mandel_colour_map #(.ITER_W(ITER_W)) u_colour_map (
    .escaped (bus.res_escaped),
    .iter    (bus.res_iter),
    .colour  (colour)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= COL_BLACK;
      x       <= '0;
      y       <= '0;
      addr    <= '0;
    end else if (abort && state != IDLE) begin
      // Abort beats every other transition; nothing further is written.
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      x       <= '0;
      y       <= '0;
      addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.px_ready) begin
            state   <= WAIT;
            valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.res_valid) begin
            state  <= WRITE;
            data_q <= colour;
            we_q   <= 1'b1;
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (x == X_LAST && y == Y_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
          end else begin
            state   <= ISSUE;
            valid_q <= 1'b1;
            addr    <= addr + AW'(1);
            if (x == X_LAST) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          x     <= '0;
          y     <= '0;
          addr  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.px_x     = x;
  assign bus.px_y     = y;
  assign bus.px_valid = valid_q;
  assign bus.fb_we    = we_q;
  assign bus.fb_addr  = addr;
  assign bus.fb_data  = data_q;

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// Randomized bench for mandel_pixel_sequencer on a 4x3 image: a behavioural
// engine model answers each coordinate after a random delay and the bench
// predicts raster order, addresses, colours and handshake timing.
module tb_mandel_pixel_sequencer;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int TN = TW * TH;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, done;

  mandel_pixel_sequencer_if #(.IMG_W(TW), .IMG_H(TH), .ITER_W(8)) bus ();

  mandel_pixel_sequencer #(.IMG_W(TW), .IMG_H(TH), .ITER_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Colour rule from the frame definition.
  function automatic logic [23:0] ref_colour(input logic esc, input logic [7:0] it);
    if (!esc) return 24'h000000;
`ifdef ITER_COLOUR_EN
    return {it, 8'h00, 8'hFF - it};
`else
    return 24'hFF0000;
`endif
  endfunction

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    abort = 1'b0;
    bus.px_ready    = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_escaped = 1'b0;
    bus.res_iter    = '0;
  endtask

  // One frame: pct = px_ready probability, hold = forced-low cycles on pixel 0,
  // abort_at = pixel index at which to abort while waiting (-1 = none).
  task automatic run_frame(input int pct, input int hold, input int abort_at);
    int n, d;
    logic rdy, esc;
    logic [7:0] it;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_valid", bus.px_valid, 1);
    check("start_busy", busy, 1);
    for (int p = 0; p < TN; p++) begin
      n = 0;
      forever begin
        check("offer_x", bus.px_x, p % TW);
        check("offer_y", bus.px_y, p / TW);
        check("offer_addr", bus.fb_addr, p);
        check("offer_valid", bus.px_valid, 1);
        check("offer_we", bus.fb_we, 0);
        if (p == 0 && n < hold) rdy = 1'b0;
        else if (n >= 40) rdy = 1'b1;
        else rdy = ($urandom_range(0, 99) < pct);
        bus.px_ready = rdy;
        if (!rdy) begin
          // Spurious result strobe and start while offering must be ignored.
          bus.res_valid = $urandom_range(0, 1);
          start = $urandom_range(0, 1);
        end
        step();
        bus.px_ready = 1'b0;
        bus.res_valid = 1'b0;
        start = 1'b0;
        n++;
        if (rdy) break;
      end
      if (p == 0 && hold > 0) check("hold_cycles", n, hold + 1);

      if (p == abort_at) begin
        check("abort_pre_valid", bus.px_valid, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", bus.px_valid, 0);
        check("abort_we", bus.fb_we, 0);
        check("abort_done", done, 0);
        check("abort_addr", bus.fb_addr, 0);
        check("abort_xy", {bus.px_x, bus.px_y}, 0);
        bus.res_valid = 1'b1;
        bus.res_escaped = 1'b1;
        step();
        bus.res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          check("late_we", bus.fb_we, 0);
          check("late_busy", busy, 0);
          check("late_done", done, 0);
          step();
        end
        return;
      end

      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        check("wait_valid", bus.px_valid, 0);
        check("wait_we", bus.fb_we, 0);
        start = $urandom_range(0, 1);
        step();
        start = 1'b0;
      end

      if (p == 1) begin
        esc = 1'b1;
        it = 8'h40;
      end else if (p == 2) begin
        esc = 1'b0;
        it = 8'($urandom);
      end else begin
        esc = 1'($urandom_range(0, 1));
        it = 8'($urandom);
      end
      bus.res_valid = 1'b1;
      bus.res_escaped = esc;
      bus.res_iter = it;
      step();
      bus.res_valid = 1'b0;
      bus.res_iter = 8'($urandom);
      check("wr_we", bus.fb_we, 1);
      check("wr_addr", bus.fb_addr, p);
      check("wr_data", bus.fb_data, ref_colour(esc, it));
      check("wr_valid", bus.px_valid, 0);
      step();
      check("wr_pulse", bus.fb_we, 0);
      if (p < TN - 1) begin
        check("next_valid", bus.px_valid, 1);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", bus.px_valid, 0);
        step();
        for (int k = 0; k < 3; k++) begin
          check("post_done", done, 0);
          check("post_busy", busy, 0);
          check("post_addr", bus.fb_addr, 0);
          check("post_xy", {bus.px_x, bus.px_y}, 0);
          check("post_we", bus.fb_we, 0);
          step();
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      check("idle_ctl", {busy, done, bus.px_valid, bus.fb_we}, 0);
      check("idle_pos", {bus.px_x, bus.px_y, bus.fb_addr}, 0);
      check("idle_data", bus.fb_data, 0);
      step();
    end

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_valid", bus.px_valid, 0);
    step();
    check("sa_busy2", busy, 0);

    run_frame(100, 0, -1);
    run_frame(100, 5, -1);
    run_frame(50, 0, 5);
    run_frame(60, 0, -1);
    run_frame(35, 3, -1);

    // Reset mid-frame clears everything like an abort.
    start = 1'b1;
    step();
    start = 1'b0;
    bus.px_ready = 1'b1;
    step();
    bus.px_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ctl", {busy, done, bus.px_valid, bus.fb_we}, 0);
    check("rst_pos", {bus.px_x, bus.px_y, bus.fb_addr}, 0);
    check("rst_data", bus.fb_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
